gpio_pad_ctrl: RTL and testbench
================================

# gpio_pad_ctrl

Per-pin controller for a bank of tri-state digital pads (`tri_pu_pad_*` / `tri_pd_pad_*`). It arbitrates each pin between software GPIO and one alternate peripheral function, and sequences direction changes so the pad never drives on the cycle its source or direction changes. It also synchronises and debounces pad input, and raises edge interrupts. It sits between the GPIO/pinmux register file and the pad ring.

## Interface
Parameters:
- `PIN_NUM`, 8, number of pads controlled.
- `DBNC_WIDTH`, 8, debounce counter and limit width.

Ports:
- `clk_i`  in  1  core clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `sw_dir_i`  in  PIN_NUM  software direction, 1 = output.
- `sw_out_i`  in  PIN_NUM  software output value.
- `sw_pull_i`  in  PIN_NUM  1 = pull resistor requested.
- `alt_sel_i`  in  PIN_NUM  1 = pin owned by alternate function.
- `alt_dir_i`  in  PIN_NUM  alternate direction, 1 = output.
- `alt_out_i`  in  PIN_NUM  alternate output value.
- `rise_en_i`  in  PIN_NUM  rising-edge interrupt enable.
- `fall_en_i`  in  PIN_NUM  falling-edge interrupt enable.
- `irq_clr_i`  in  PIN_NUM  single-cycle pending clear.
- `dbnc_lim_i`  in  DBNC_WIDTH  debounce limit L, shared by all pins.
- `pad_c_i`  in  PIN_NUM  pad receiver outputs (`c_o` of the pads).
- `pad_i_o`  out  PIN_NUM  pad drive data.
- `pad_oen_o`  out  PIN_NUM  pad output enable, active-low.
- `pad_ren_o`  out  PIN_NUM  pad resistor enable, active-low.
- `in_o`  out  PIN_NUM  synchronised, debounced input value.
- `irq_pend_o`  out  PIN_NUM  sticky edge-pending flags.
- `irq_o`  out  1  OR of `irq_pend_o`.

## Operation
- Effective source per pin: `alt_sel_i` ? alt_* : sw_*. Pull always comes from `sw_pull_i`.
- Each pin runs a direction FSM with states IN, TURN and OUT. Reset state is IN.
  - IN: `pad_oen_o`=1. If the effective dir is 1, go to TURN.
  - TURN: `pad_oen_o`=1. If the effective dir is 1, go to OUT; otherwise go to IN.
  - OUT: `pad_oen_o`=0. If the effective dir is 0, go to IN. If `alt_sel_i` differs from its previous-cycle value and the effective dir is 1, go to TURN for glitch-free handover.
- `pad_i_o` is registered from the effective out value every cycle, independent of state.
- `pad_ren_o` is registered. It is 1 (pull off) in OUT; otherwise it is `~sw_pull_i`.
- Input path is a 2-FF synchroniser on `pad_c_i`, giving `s2`.
- Debounce, per pin, counter `cnt`:
  - If `s2 == in_o`: `cnt` ← 0.
  - Else if `cnt == L`: `in_o` ← `s2` and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
  - L=0 means `in_o` follows `s2` with one register.
  - A pad level held fewer than L+1 cycles after synchronisation is rejected.
- Edge detect uses `in_q`, the previous `in_o`.
  - rise = `in_o` & ~`in_q`; fall = ~`in_o` & `in_q`.
  - `irq_pend_o` sets on (rise & `rise_en_i`) | (fall & `fall_en_i`).
  - `irq_pend_o` clears on `irq_clr_i`. Simultaneous set and clear: set wins.
- Changing enables never clears pending flags.
- `irq_o` is the combinational OR of the pending flops.

## Timing
- Reset values:
  - `pad_oen_o` = all 1; `pad_i_o` = 0; `pad_ren_o` = 0 (pull on).
  - `in_o` = 0; `irq_pend_o` = 0; `irq_o` = 0.
  - Synchroniser, `in_q` and `cnt` = 0.
- Input→output: dir rises at edge N, giving TURN at N+1 (`pad_i_o` valid), OUT at N+2 (`pad_oen_o`=0).
- Output→input: dir falls at edge N, giving `pad_oen_o`=1 at N+1.
- Pad→`in_o` latency: 3+L edges with debounce.
- `in_o`→`irq_pend_o` latency: 1 edge.
- Counter saturation is impossible because `cnt` ≤ L.
- Changing `dbnc_lim_i` mid-count compares against the new L. If `cnt` > new L, the next mismatching cycle treats the count as reached.
- Reset asserted mid-operation immediately releases every pad to input (oen=1) and clears all state.

## Configuration
- `GPIO_PAD_CTRL_DBNC_EN` defined: debounce counters are present as above.
- `GPIO_PAD_CTRL_DBNC_EN` undefined:
  - No counters; `in_o` = `s2`, so pad→`in_o` latency is 2 edges.
  - `dbnc_lim_i` is ignored.
  - Interrupt logic is unchanged.

## Test plan
- Reset released, all inputs 0 → `pad_oen_o`=0xFF, `pad_ren_o`=0x00, `irq_o`=0.
- Pin 0: `sw_out_i`=1, `sw_dir_i` 0→1 at edge N → `pad_i_o[0]`=1 at N+1 with oen still 1, then `pad_oen_o[0]`=0 at N+2. `sw_dir_i`→0 → oen=1 one edge later.
- Pin 3 in OUT driven by sw=0; `alt_sel_i[3]`=1 with alt_dir=1, alt_out=1 → one TURN cycle with oen=1, then OUT with `pad_i_o[3]`=1.
- L=4, `rise_en_i[2]`=1:
  - `pad_c_i[2]` high for 3 cycles → no `in_o` change.
  - `pad_c_i[2]` held high → `in_o[2]`=1 after 7 edges, `irq_pend_o[2]`=1 after 8, `irq_o`=1.
- Pending pin 2: `irq_clr_i[2]` pulsed in the same cycle as a new falling edge with `fall_en_i[2]`=1 → pending stays 1. A later lone clear → 0.
- Macro undefined → pad step to `in_o` in exactly 2 edges regardless of `dbnc_lim_i`=0xFF.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// Per-pin pad controller: GPIO/alternate-function arbitration, sequenced direction changes,
// input sync + debounce and edge interrupts. Define GPIO_PAD_CTRL_DBNC_EN to include debounce counters.
module gpio_pad_ctrl #(
    parameter int PIN_NUM    = 8,
    parameter int DBNC_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [PIN_NUM-1:0]    sw_dir_i,
    input  logic [PIN_NUM-1:0]    sw_out_i,
    input  logic [PIN_NUM-1:0]    sw_pull_i,
    input  logic [PIN_NUM-1:0]    alt_sel_i,
    input  logic [PIN_NUM-1:0]    alt_dir_i,
    input  logic [PIN_NUM-1:0]    alt_out_i,
    input  logic [PIN_NUM-1:0]    rise_en_i,
    input  logic [PIN_NUM-1:0]    fall_en_i,
    input  logic [PIN_NUM-1:0]    irq_clr_i,
    input  logic [DBNC_WIDTH-1:0] dbnc_lim_i,
    input  logic [PIN_NUM-1:0]    pad_c_i,
    output logic [PIN_NUM-1:0]    pad_i_o,
    output logic [PIN_NUM-1:0]    pad_oen_o,
    output logic [PIN_NUM-1:0]    pad_ren_o,
    output logic [PIN_NUM-1:0]    in_o,
    output logic [PIN_NUM-1:0]    irq_pend_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {
        ST_IN   = 2'd0,
        ST_TURN = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    logic [PIN_NUM-1:0] w_eff_dir;
    logic [PIN_NUM-1:0] w_eff_out;
    logic [PIN_NUM-1:0] w_alt_chg;
    logic [PIN_NUM-1:0] w_oen;
    logic [PIN_NUM-1:0] w_to_out;
    logic [PIN_NUM-1:0] w_in;
    logic [PIN_NUM-1:0] w_rise;
    logic [PIN_NUM-1:0] w_fall;
    logic [PIN_NUM-1:0] r_alt_q;
    logic [PIN_NUM-1:0] r_pad_i;
    logic [PIN_NUM-1:0] r_pad_ren;
    logic [PIN_NUM-1:0] r_s1;
    logic [PIN_NUM-1:0] r_s2;
    logic [PIN_NUM-1:0] r_in_q;
    logic [PIN_NUM-1:0] r_pend;

    assign w_eff_dir = (alt_sel_i & alt_dir_i) | (~alt_sel_i & sw_dir_i);
    assign w_eff_out = (alt_sel_i & alt_out_i) | (~alt_sel_i & sw_out_i);
    assign w_alt_chg = alt_sel_i ^ r_alt_q;

    for (genvar g = 0; g < PIN_NUM; g++) begin : g_dir
        state_t r_state;
        state_t w_next;
        logic   w_oen_pin;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) r_state <= ST_IN;
            else          r_state <= w_next;
        end

        // A source handover while driving passes through TURN so the pad never drives mid-switch.
        always_comb begin
            w_next    = r_state;
            w_oen_pin = 1'b1;
            case (r_state)
                ST_IN:   if (w_eff_dir[g]) w_next = ST_TURN;
                ST_TURN: w_next = w_eff_dir[g] ? ST_OUT : ST_IN;
                ST_OUT: begin
                    w_oen_pin = 1'b0;
                    if (!w_eff_dir[g])    w_next = ST_IN;
                    else if (w_alt_chg[g]) w_next = ST_TURN;
                end
                default: w_next = ST_IN;
            endcase
        end

        assign w_oen[g]    = w_oen_pin;
        assign w_to_out[g] = (w_next == ST_OUT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_alt_q   <= '0;
            r_pad_i   <= '0;
            r_pad_ren <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
        end else begin
            r_alt_q   <= alt_sel_i;
            r_pad_i   <= w_eff_out;
            r_pad_ren <= w_to_out | ~sw_pull_i;
            r_s1      <= pad_c_i;
            r_s2      <= r_s1;
        end
    end

`ifdef GPIO_PAD_CTRL_DBNC_EN
    for (genvar g = 0; g < PIN_NUM; g++) begin : g_dbnc
        logic                  r_in_pin;
        logic [DBNC_WIDTH-1:0] r_cnt;

        // >= so that lowering the limit below a running count resolves on the next mismatch.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_in_pin <= 1'b0;
                r_cnt    <= '0;
            end else if (r_s2[g] == r_in_pin) begin
                r_cnt    <= '0;
            end else if (r_cnt >= dbnc_lim_i) begin
                r_in_pin <= r_s2[g];
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + DBNC_WIDTH'(1);
            end
        end

        assign w_in[g] = r_in_pin;
    end
`else
    logic w_unused_lim;
    assign w_unused_lim = ^dbnc_lim_i;
    assign w_in         = r_s2;
`endif

    assign w_rise = w_in & ~r_in_q;
    assign w_fall = ~w_in & r_in_q;

    // New edges take priority over a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_in_q <= '0;
            r_pend <= '0;
        end else begin
            r_in_q <= w_in;
            r_pend <= (r_pend & ~irq_clr_i) | (w_rise & rise_en_i) | (w_fall & fall_en_i);
        end
    end

    assign pad_i_o    = r_pad_i;
    assign pad_oen_o  = w_oen;
    assign pad_ren_o  = r_pad_ren;
    assign in_o       = w_in;
    assign irq_pend_o = r_pend;
    assign irq_o      = |r_pend;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed testbench for gpio_pad_ctrl: table of direction/handover vectors plus
// hand-written debounce, interrupt and reset sequences (latencies follow GPIO_PAD_CTRL_DBNC_EN).
module tb_gpio_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_dir, sw_out, sw_pull, alt_sel, alt_dir, alt_out;
    logic [7:0] rise_en, fall_en, irq_clr, dbnc_lim, pad_c;
    logic [7:0] pad_i, pad_oen, pad_ren, in_v, irq_pend;
    logic       irq;

    int n_chk = 0;
    int n_err = 0;

`ifdef GPIO_PAD_CTRL_DBNC_EN
    localparam int LIM = 4;
    localparam int LAT = 3 + LIM;
`else
    localparam int LIM = 255;
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [7:0] sw_dir;
        logic [7:0] sw_out;
        logic [7:0] sw_pull;
        logic [7:0] alt_sel;
        logic [7:0] alt_dir;
        logic [7:0] alt_out;
        logic [7:0] e_pad_i;
        logic [7:0] e_oen;
        logic [7:0] e_ren;
    } vec_t;

    vec_t tbl [20];

    gpio_pad_ctrl #(.PIN_NUM(8), .DBNC_WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .sw_dir_i   (sw_dir),
        .sw_out_i   (sw_out),
        .sw_pull_i  (sw_pull),
        .alt_sel_i  (alt_sel),
        .alt_dir_i  (alt_dir),
        .alt_out_i  (alt_out),
        .rise_en_i  (rise_en),
        .fall_en_i  (fall_en),
        .irq_clr_i  (irq_clr),
        .dbnc_lim_i (dbnc_lim),
        .pad_c_i    (pad_c),
        .pad_i_o    (pad_i),
        .pad_oen_o  (pad_oen),
        .pad_ren_o  (pad_ren),
        .in_o       (in_v),
        .irq_pend_o (irq_pend),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw_dir = '0; sw_out = '0; sw_pull = '0; alt_sel = '0; alt_dir = '0; alt_out = '0;
        rise_en = '0; fall_en = '0; irq_clr = '0; dbnc_lim = '0; pad_c = '0;

        //           dir    out    pull   asel   adir   aout   pad_i  oen    ren
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        tbl[1]  = '{8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0};
        tbl[2]  = '{8'h00, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hF0};
        tbl[3]  = '{8'h01, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hF0};
        tbl[4]  = '{8'h01, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hF1};
        tbl[5]  = '{8'h00, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hF0};
        tbl[6]  = '{8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0};
        tbl[7]  = '{8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF7, 8'hF8};
        tbl[8]  = '{8'h08, 8'h00, 8'h0F, 8'h08, 8'h08, 8'h08, 8'h08, 8'hFF, 8'hF0};
        tbl[9]  = '{8'h08, 8'h00, 8'h0F, 8'h08, 8'h08, 8'h08, 8'h08, 8'hF7, 8'hF8};
        tbl[10] = '{8'h08, 8'h00, 8'h0F, 8'h08, 8'h08, 8'h08, 8'h08, 8'hF7, 8'hF8};
        tbl[11] = '{8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0};
        tbl[12] = '{8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF7, 8'hF8};
        tbl[13] = '{8'h08, 8'h00, 8'h0F, 8'h08, 8'h00, 8'h08, 8'h08, 8'hFF, 8'hF0};
        tbl[14] = '{8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0};
        tbl[15] = '{8'h00, 8'h00, 8'h0F, 8'h02, 8'h02, 8'h02, 8'h02, 8'hFF, 8'hF0};
        tbl[16] = '{8'h00, 8'h00, 8'h0F, 8'h02, 8'h02, 8'h02, 8'h02, 8'hFD, 8'hF2};
        tbl[17] = '{8'h02, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0};
        tbl[18] = '{8'h02, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hF2};
        tbl[19] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};

        repeat (2) tick();
        chk("rst_oen",   32'(pad_oen),  32'hFF);
        chk("rst_pad_i", 32'(pad_i),    32'h00);
        chk("rst_ren",   32'(pad_ren),  32'h00);
        chk("rst_in",    32'(in_v),     32'h00);
        chk("rst_pend",  32'(irq_pend), 32'h00);
        chk("rst_irq",   32'(irq),      32'h0);

        rst_n = 1'b1;
        #1;
        chk("rel_oen", 32'(pad_oen), 32'hFF);
        chk("rel_ren", 32'(pad_ren), 32'h00);
        chk("rel_irq", 32'(irq),     32'h0);

        for (int i = 0; i < 20; i++) begin
            sw_dir  = tbl[i].sw_dir;
            sw_out  = tbl[i].sw_out;
            sw_pull = tbl[i].sw_pull;
            alt_sel = tbl[i].alt_sel;
            alt_dir = tbl[i].alt_dir;
            alt_out = tbl[i].alt_out;
            tick();
            chk($sformatf("vec%0d_pad_i", i), 32'(pad_i),   32'(tbl[i].e_pad_i));
            chk($sformatf("vec%0d_oen", i),   32'(pad_oen), 32'(tbl[i].e_oen));
            chk($sformatf("vec%0d_ren", i),   32'(pad_ren), 32'(tbl[i].e_ren));
        end

        dbnc_lim = 8'(LIM);
        rise_en  = 8'h04;
        fall_en  = 8'h00;

`ifdef GPIO_PAD_CTRL_DBNC_EN
        pad_c = 8'h04;
        repeat (3) tick();
        pad_c = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("glitch_in_%0d", k), 32'(in_v), 32'h00);
        end
        chk("glitch_pend", 32'(irq_pend), 32'h00);
`endif

        pad_c = 8'h04;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk($sformatf("rise_in_e%0d", k), 32'(in_v), (k == LAT) ? 32'h04 : 32'h00);
        end
        chk("rise_pend_early", 32'(irq_pend), 32'h00);
        tick();
        chk("rise_pend", 32'(irq_pend), 32'h04);
        chk("rise_irq",  32'(irq),      32'h1);

        rise_en = 8'h00;
        tick();
        chk("en_off_pend", 32'(irq_pend), 32'h04);

        fall_en = 8'h04;
        pad_c   = 8'h00;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk($sformatf("fall_in_e%0d", k), 32'(in_v), (k == LAT) ? 32'h00 : 32'h04);
        end
        irq_clr = 8'h04;
        tick();
        irq_clr = 8'h00;
        chk("set_wins_pend", 32'(irq_pend), 32'h04);
        tick();
        chk("hold_pend", 32'(irq_pend), 32'h04);
        irq_clr = 8'h04;
        tick();
        irq_clr = 8'h00;
        chk("clr_pend", 32'(irq_pend), 32'h00);
        chk("clr_irq",  32'(irq),      32'h0);

        sw_dir = 8'h01;
        sw_out = 8'h01;
        repeat (2) tick();
        chk("pre_rst_oen", 32'(pad_oen), 32'hFE);
        rst_n = 1'b0;
        #1;
        chk("midrst_oen",   32'(pad_oen), 32'hFF);
        chk("midrst_pad_i", 32'(pad_i),   32'h00);
        chk("midrst_ren",   32'(pad_ren), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
